// File: rtl/multdiv_pkg.sv
// Shared multdiv definitions: phase codes from the division counter, widths, divider state type.
package multdiv_pkg;
  localparam logic [1:0] PH_LOAD  = 2'b01;
  localparam logic [1:0] PH_ITER  = 2'b00;
  localparam logic [1:0] PH_FINAL = 2'b10;

  localparam int         DIV_WIDTH      = 32;
  localparam logic [5:0] DIV_LAST_STATE = 6'd33;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on magnitudes: shift {R,Q} left, subtract D if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_trial;
  logic             w_neg;

  // One spare bit above the shifted remainder lets the trial's sign bit flag "does not fit".
  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_trial   = w_shifted - {2'b00, i_div};
  assign w_neg     = w_trial[WIDTH+1];

  assign o_rem = w_neg ? w_shifted[WIDTH:0] : w_trial[WIDTH:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};
endmodule

// File: rtl/div_iter_datapath.sv
// Iterative signed restoring divider driven by the division counter's phase code.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module div_iter_datapath
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       ctrl_phase,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             busy
);
  localparam int SW = $clog2(WIDTH) + 1;

  div_state_e       r_state, w_state_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_qsign;
  logic             r_dz;
  logic [SW-1:0]    r_step;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;
`ifdef DIV_REMAINDER_EN
  logic             r_rsign;
  logic [WIDTH-1:0] r_remainder;
`endif

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_can_iter;

  // Negating 0x80000000 yields itself, which is the correct unsigned magnitude.
  assign w_a_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_b_mag    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign w_can_iter = (r_state == ST_RUN) && (r_step < SW'(WIDTH));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_next),
    .o_quo (w_quo_next)
  );

  always_comb begin
    w_state_next = r_state;
    case (ctrl_phase)
      PH_LOAD:  w_state_next = ST_RUN;
      PH_FINAL: w_state_next = ST_IDLE;
      default:  w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_qsign  <= 1'b0;
      r_dz     <= 1'b0;
      r_step   <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
`ifdef DIV_REMAINDER_EN
      r_rsign     <= 1'b0;
      r_remainder <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_rdy   <= 1'b0;
      case (ctrl_phase)
        PH_LOAD: begin
          r_rem   <= '0;
          r_quo   <= w_a_mag;
          r_div   <= w_b_mag;
          r_qsign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          r_dz    <= (data_operandB == '0);
          r_step  <= '0;
`ifdef DIV_REMAINDER_EN
          r_rsign <= data_operandA[WIDTH-1];
`endif
        end
        PH_ITER: begin
          if (w_can_iter) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_step <= r_step + 1'b1;
          end
        end
        PH_FINAL: begin
          if (r_state == ST_RUN) begin
            r_result <= r_dz ? '0 : (r_qsign ? -r_quo : r_quo);
            r_exc    <= r_dz | (r_step != SW'(WIDTH));
            r_rdy    <= 1'b1;
`ifdef DIV_REMAINDER_EN
            r_remainder <= r_dz ? '0 : (r_rsign ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state == ST_RUN);
`ifdef DIV_REMAINDER_EN
  assign data_remainder = r_remainder;
`endif
endmodule

// File: tb/tb_div_iter_datapath.sv
// Self-checking bench for div_iter_datapath: directed corner cases plus random operands vs. an arithmetic model.
module tb_div_iter_datapath;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ctrl_phase;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_count = 0;

  always #5 clock = ~clock;

  div_iter_datapath #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_phase     (ctrl_phase),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .busy           (busy)
  );

  always @(posedge clock) if (data_resultRDY) rdy_count++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a phase for one cycle; returns at the next falling edge so outputs reflect that cycle's edge.
  task automatic cyc(input logic [1:0] ph);
    ctrl_phase = ph;
    @(negedge clock);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int n_iter, input bit chk_q);
    longint sa, sb, q, r;
    logic [31:0] exp_q, exp_r;
    bit exp_exc;
    int rc0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin q = 0; r = 0; end
    else begin q = sa / sb; r = sa % sb; end
    exp_q   = q[31:0];
    exp_r   = r[31:0];
    exp_exc = (b == 32'd0) || (n_iter < 32);
    rc0 = rdy_count;
    data_operandA = a;
    data_operandB = b;
    cyc(2'b01);
    check_val("busy_after_load", {31'd0, busy}, 32'd1);
    repeat (n_iter) cyc(2'b00);
    check_val("rdy_before_final", {31'd0, data_resultRDY}, 32'd0);
    cyc(2'b10);
    check_val("rdy_pulse", {31'd0, data_resultRDY}, 32'd1);
    check_val("busy_after_final", {31'd0, busy}, 32'd0);
    check_val("exception", {31'd0, data_exception}, {31'd0, exp_exc});
    if (chk_q) check_val("quotient", data_result, exp_q);
`ifdef DIV_REMAINDER_EN
    if (chk_q) check_val("remainder", data_remainder, exp_r);
`endif
    cyc(2'b11);
    check_val("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    check_val("rdy_count", rdy_count - rc0, 32'd1);
    check_val("result_held", data_result, chk_q ? exp_q : data_result);
    $display("txn A=%h B=%h iters=%0d result=%h exc=%b exp_q=%h exp_r=%h", a, b, n_iter,
             data_result, data_exception, exp_q, exp_r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0;
    logic [31:0] ra, rb;
    reset = 1'b1;
    ctrl_phase = 2'b11;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check_val("reset_result", data_result, 32'd0);
    check_val("reset_exc", {31'd0, data_exception}, 32'd0);
    check_val("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check_val("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    cyc(2'b11);

    run_div(32'd100, 32'd7, 32, 1'b1);
    run_div(-32'sd100, 32'd7, 32, 1'b1);
    run_div(32'd100, -32'sd7, 32, 1'b1);
    run_div(32'd5, 32'd0, 32, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 32, 1'b1);
    run_div(32'h7FFF_FFFF, 32'd1, 32, 1'b1);
    run_div(32'd100, 32'd7, 31, 1'b0);
    run_div(32'd100, 32'd7, 34, 1'b1);

    // Restart mid-division: the second load wins, one ready pulse overall.
    rc0 = rdy_count;
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    cyc(2'b01);
    repeat (10) cyc(2'b00);
    run_div(32'd9, 32'd3, 32, 1'b1);
    check_val("restart_single_rdy", rdy_count - rc0, 32'd1);

    // Reset mid-division aborts silently; a later finalize is ignored.
    rc0 = rdy_count;
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    cyc(2'b01);
    repeat (20) cyc(2'b00);
    reset = 1'b1;
    cyc(2'b11);
    reset = 1'b0;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_result", data_result, 32'd0);
    cyc(2'b10);
    check_val("idle_final_rdy", {31'd0, data_resultRDY}, 32'd0);
    check_val("idle_final_busy", {31'd0, busy}, 32'd0);
    cyc(2'b11);
    check_val("abort_no_rdy", rdy_count - rc0, 32'd0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 5)
        0: rb = rb >> $urandom_range(31, 16);
        1: rb = 32'd0;
        2: ra = ra >> $urandom_range(31, 0);
        default: ;
      endcase
      run_div(ra, rb, 32, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
